// File: rtl/boot_loader_ctrl_pkg.sv
// Shared boot-loader definitions: frame start byte, RAM base address and FSM state encodings.
// Imported by the loader and by anything that decodes its state for debug.
package boot_loader_ctrl_pkg;

   localparam logic [7:0]  BOOT_MAGIC     = 8'hA5;
   localparam logic [31:0] BOOT_BASE_ADDR = 32'h0000_0000;

   typedef enum logic [2:0] {
      BOOT_S_WAIT_MAGIC = 3'd0,
      BOOT_S_LEN_LO     = 3'd1,
      BOOT_S_LEN_HI     = 3'd2,
      BOOT_S_DATA       = 3'd3,
      BOOT_S_CSUM       = 3'd4,
      BOOT_S_RUN        = 3'd5,
      BOOT_S_ERR        = 3'd6
   } boot_state_t;

endpackage

// File: rtl/boot_loader_ctrl.sv
// UART boot loader and RAM port owner: loads a framed image as 32-bit words, then hands the port to the CPU.
// RAM write lands 1 clk after the 4th byte; no backpressure, rx bytes may arrive back-to-back.
module boot_loader_ctrl
   import boot_loader_ctrl_pkg::*;
#(
   parameter logic [7:0]  MAGIC     = BOOT_MAGIC,
   parameter logic [31:0] BASE_ADDR = BOOT_BASE_ADDR,
   parameter int unsigned MAX_WORDS = 4096,
   parameter int unsigned TIMEOUT   = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic [31:0] cpu_addr,
   input  logic        cpu_we,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] ram_addr,
   output logic        ram_we,
   output logic [31:0] ram_wdata,
   output logic        cpu_rst,
   output logic        boot_done,
   output logic        boot_err
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [15:0]   MAX_LEN   = 16'(MAX_WORDS);

   boot_state_t state, next_state;

   logic [15:0]   len;
   logic [15:0]   word_cnt;
   logic [1:0]    byte_idx;
   logic [23:0]   word_buf;
   logic [7:0]    csum;
   logic [TW-1:0] tmo_cnt;
   logic          ld_we;
   logic [31:0]   ld_addr;
   logic [31:0]   ld_wdata;

   logic          magic_hit;
   logic          tmo_active;
   logic [15:0]   len_full;

   always_comb begin
      next_state = state;
      magic_hit  = 1'b0;
      tmo_active = 1'b0;
      len_full   = {rx_data, len[7:0]};
      case (state)
         BOOT_S_WAIT_MAGIC: begin
            if (rx_valid && rx_data == MAGIC) begin
               magic_hit  = 1'b1;
               next_state = BOOT_S_LEN_LO;
            end
         end
         BOOT_S_LEN_LO: begin
            tmo_active = 1'b1;
            if (rx_valid) next_state = BOOT_S_LEN_HI;
         end
         BOOT_S_LEN_HI: begin
            tmo_active = 1'b1;
            if (rx_valid) begin
               if (len_full == 16'd0)        next_state = BOOT_S_CSUM;
               else if (len_full > MAX_LEN)  next_state = BOOT_S_ERR;
               else                          next_state = BOOT_S_DATA;
            end
         end
         BOOT_S_DATA: begin
            tmo_active = 1'b1;
            if (rx_valid && byte_idx == 2'd3 && (word_cnt + 16'd1) == len)
               next_state = BOOT_S_CSUM;
         end
         BOOT_S_CSUM: begin
            tmo_active = 1'b1;
            if (rx_valid) next_state = (rx_data == csum) ? BOOT_S_RUN : BOOT_S_ERR;
         end
         BOOT_S_RUN:  next_state = BOOT_S_RUN;
         BOOT_S_ERR:  next_state = BOOT_S_WAIT_MAGIC;
         default:     next_state = BOOT_S_WAIT_MAGIC;
      endcase
      // Inter-byte silence aborts the frame; a byte arriving on the last cycle still wins.
      if (tmo_active && !rx_valid && tmo_cnt == TMO_LAST)
         next_state = BOOT_S_ERR;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= BOOT_S_WAIT_MAGIC;
         cpu_rst   <= 1'b1;
         boot_done <= 1'b0;
         boot_err  <= 1'b0;
      end else begin
         state     <= next_state;
         cpu_rst   <= (next_state != BOOT_S_RUN);
         boot_done <= (next_state == BOOT_S_RUN);
         if (next_state == BOOT_S_ERR) boot_err <= 1'b1;
         else if (magic_hit)           boot_err <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len      <= '0;
         word_cnt <= '0;
         byte_idx <= '0;
         word_buf <= '0;
         csum     <= '0;
         tmo_cnt  <= '0;
         ld_we    <= 1'b0;
         ld_addr  <= '0;
         ld_wdata <= '0;
      end else begin
         ld_we <= 1'b0;
         if (tmo_active) tmo_cnt <= rx_valid ? '0 : tmo_cnt + 1'b1;
         else            tmo_cnt <= '0;
         case (state)
            BOOT_S_WAIT_MAGIC: begin
               if (magic_hit) begin
                  len      <= '0;
                  word_cnt <= '0;
                  byte_idx <= '0;
                  csum     <= '0;
               end
            end
            BOOT_S_LEN_LO: if (rx_valid) len[7:0]  <= rx_data;
            BOOT_S_LEN_HI: if (rx_valid) len[15:8] <= rx_data;
            BOOT_S_DATA: begin
               if (rx_valid) begin
                  csum     <= csum ^ rx_data;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     // Top byte goes straight into the write word; the buffer only holds bytes 0..2.
                     ld_we    <= 1'b1;
                     ld_addr  <= BASE_ADDR + {14'd0, word_cnt, 2'b00};
                     ld_wdata <= {rx_data, word_buf};
                     word_cnt <= word_cnt + 16'd1;
                  end else begin
                     word_buf[{byte_idx, 3'b000} +: 8] <= rx_data;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      ram_addr  = ld_addr;
      ram_we    = ld_we;
      ram_wdata = ld_wdata;
      if (state == BOOT_S_RUN) begin
         ram_addr  = cpu_addr;
         ram_we    = cpu_we;
         ram_wdata = cpu_wdata;
      end
   end

endmodule
